// File: rtl/decode_fetch_unescape.sv
// decode_fetch_unescape: strips prefixes and 0x0F escape, packs the body into a 72-bit window; `FETCH_ERR_DETECT_EN adds malformed-instruction detection
module decode_fetch_unescape #(
  parameter int MAX_INSTR_LEN = 15,
  parameter int BODY_BYTES = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_byte,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*BODY_BYTES-1:0] unescaped_instr,
  output logic                    prefix_operand_16bit,
  output logic                    prefix_address_16bit,
  output logic                    prefix_rep,
  output logic                    prefix_lock,
  output logic                    escape_0f,
  output logic [3:0]              body_len,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
`ifdef FETCH_ERR_DETECT_EN
  typedef enum logic [1:0] {S_PREFIX, S_BODY, S_DRAIN, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_PREFIX, S_BODY, S_DONE} state_t;
`endif
  state_t state, state_nx;
  logic acc, is_pfx, is_esc, ovf, clr;
  logic [3:0] tot_cnt;
  assign in_ready = state != S_DONE;
  assign out_valid = state == S_DONE;
  assign acc = in_valid && in_ready;
  assign is_pfx = in_byte inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3};
  assign is_esc = in_byte == 8'h0F;
  assign ovf = body_len == 4'(BODY_BYTES) || tot_cnt == 4'(MAX_INSTR_LEN);
  assign clr = rst || (out_valid && out_ready);
  // State register
  always_ff @(posedge clk)
    state <= rst ? S_PREFIX : state_nx;
  // Next state: prefixes loop, first non-prefix enters the body, in_last closes the instruction
  always_comb begin
    state_nx = state;
    case (state)
      S_PREFIX: state_nx = !acc ? S_PREFIX : in_last ? S_DONE : is_pfx ? S_PREFIX : S_BODY;
`ifdef FETCH_ERR_DETECT_EN
      S_BODY:   state_nx = !acc ? S_BODY : in_last ? S_DONE : ovf ? S_DRAIN : S_BODY;
      S_DRAIN:  state_nx = acc && in_last ? S_DONE : S_DRAIN;
`else
      S_BODY:   state_nx = acc && in_last ? S_DONE : S_BODY;
`endif
      S_DONE:   state_nx = out_ready ? S_PREFIX : S_DONE;
      default:  state_nx = S_PREFIX;
    endcase
  end
  // Collect flags and body bytes; the window is cleared once the instruction is consumed
  always_ff @(posedge clk) begin
    if (clr) begin
      unescaped_instr <= '0;
      prefix_operand_16bit <= 1'b0;
      prefix_address_16bit <= 1'b0;
      prefix_rep <= 1'b0;
      prefix_lock <= 1'b0;
      escape_0f <= 1'b0;
      body_len <= 4'd0;
      tot_cnt <= 4'd0;
    end else if (acc) begin
      tot_cnt <= tot_cnt == 4'(MAX_INSTR_LEN) ? tot_cnt : tot_cnt + 4'd1;
      if (state == S_PREFIX) begin
        prefix_operand_16bit <= prefix_operand_16bit | (in_byte == 8'h66);
        prefix_address_16bit <= prefix_address_16bit | (in_byte == 8'h67);
        prefix_rep <= prefix_rep | (in_byte == 8'hF2) | (in_byte == 8'hF3);
        prefix_lock <= prefix_lock | (in_byte == 8'hF0);
        escape_0f <= is_esc;
        if (!is_pfx && !is_esc) begin
          unescaped_instr[7:0] <= in_byte;
          body_len <= 4'd1;
        end
      end else if (state == S_BODY && !ovf) begin
        for (int k = 0; k < BODY_BYTES; k++)
          if (body_len == 4'(k)) unescaped_instr[8*k +: 8] <= in_byte;
        body_len <= body_len + 4'd1;
      end
    end
  end
`ifdef FETCH_ERR_DETECT_EN
  // Flag an empty body (prefix/escape carrying in_last) or an overlong body
  always_ff @(posedge clk)
    if (clr) out_err <= 1'b0;
    else if (acc && ((state == S_PREFIX && in_last && (is_pfx || is_esc)) || (state == S_BODY && ovf))) out_err <= 1'b1;
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_decode_fetch_unescape.sv
// tb_decode_fetch_unescape: table-driven scoreboard bench for decode_fetch_unescape
module tb_decode_fetch_unescape;
  logic clk = 1'b0;
  logic rst, in_last, in_valid, in_ready, out_ready, out_valid, out_err;
  logic [7:0] in_byte;
  logic [71:0] unescaped_instr;
  logic prefix_operand_16bit, prefix_address_16bit, prefix_rep, prefix_lock, escape_0f;
  logic [3:0] body_len;
  always #5 clk = ~clk;
  decode_fetch_unescape dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .unescaped_instr(unescaped_instr), .prefix_operand_16bit(prefix_operand_16bit),
    .prefix_address_16bit(prefix_address_16bit), .prefix_rep(prefix_rep), .prefix_lock(prefix_lock),
    .escape_0f(escape_0f), .body_len(body_len), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );
`ifdef FETCH_ERR_DETECT_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  typedef struct {
    logic [127:0] b;
    int n;
    logic [71:0] win;
    logic [4:0] flags;
    logic [3:0] len;
    logic err;
  } vec_t;
  typedef struct {
    logic [71:0] win;
    logic [4:0] flags;
    logic [3:0] len;
    logic err;
  } exp_t;
  exp_t sb[$];
  vec_t v[12];
  int n_vec = 0;
  int n_bad = 0;
  function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  function automatic logic [4:0] flags_now();
    return {prefix_operand_16bit, prefix_address_16bit, prefix_rep, prefix_lock, escape_0f};
  endfunction
  // Scoreboard: compare each consumed instruction against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got window %h with no expectation queued", unescaped_instr);
      end else begin
        e = sb.pop_front();
        check("window", unescaped_instr, e.win);
        check("flags", 72'(flags_now()), 72'(e.flags));
        check("body_len", 72'(body_len), 72'(e.len));
        check("out_err", 72'(out_err), 72'(e.err));
      end
    end
  end
  task automatic send(input logic [127:0] b, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      in_byte = b[8*i +: 8];
      in_last = (i == n - 1);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL in_ready_timeout: got in_ready 0 required 1 within 50 cycles");
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic push(input logic [71:0] win, input logic [4:0] flags, input logic [3:0] len, input logic err);
    exp_t e;
    e.win = win;
    e.flags = flags;
    e.len = len;
    e.err = err;
    sb.push_back(e);
  endtask
  task automatic drain();
    for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clk);
    #1;
    check("scoreboard_drain", 72'(sb.size()), 72'd0);
  endtask
  task automatic check_idle(string tag);
    check({tag, "_out_valid"}, 72'(out_valid), 72'd0);
    check({tag, "_in_ready"}, 72'(in_ready), 72'd1);
    check({tag, "_window"}, unescaped_instr, 72'd0);
    check({tag, "_flags"}, 72'(flags_now()), 72'd0);
    check({tag, "_body_len"}, 72'(body_len), 72'd0);
    check({tag, "_out_err"}, 72'(out_err), 72'd0);
  endtask
  initial begin
    // flags field: {operand_16bit, address_16bit, rep, lock, escape_0f}
    v[0]  = '{128'hD801, 2, 72'hD801, 5'b00000, 4'd2, 1'b0};
    v[1]  = '{128'hC3AF0F6766, 5, 72'hC3AF, 5'b11001, 4'd2, 1'b0};
    v[2]  = '{128'hA42EF3, 3, 72'hA4, 5'b00100, 4'd1, 1'b0};
    v[3]  = '{128'h050F0FF2F0, 5, 72'h050F, 5'b00111, 4'd2, 1'b0};
    v[4]  = '{128'h90366564263E, 6, 72'h90, 5'b00000, 4'd1, 1'b0};
    v[5]  = '{128'h909090909090909090909066, 12, 72'h909090909090909090, 5'b10000, 4'd9, ERR};
    v[6]  = '{128'h66, 1, 72'h0, 5'b10000, 4'd0, ERR};
    v[7]  = '{128'h0F, 1, 72'h0, 5'b00001, 4'd0, ERR};
    v[8]  = '{128'h08070605040302018B, 9, 72'h08070605040302018B, 5'b00000, 4'd9, 1'b0};
    v[9]  = '{128'hF06690, 3, 72'hF06690, 5'b00000, 4'd3, 1'b0};
    v[10] = '{128'h9988776655443322110F2EF36766F0, 15, 72'h998877665544332211, 5'b11111, 4'd9, 1'b0};
    v[11] = '{128'h380F0F, 3, 72'h380F, 5'b00001, 4'd2, 1'b0};
    rst = 1'b1;
    in_byte = 8'h00;
    in_last = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push(v[i].win, v[i].flags, v[i].len, v[i].err);
      send(v[i].b, v[i].n);
    end
    drain();
    // Backpressure: outputs must hold while out_ready is low
    out_ready = 1'b0;
    push(72'hD801, 5'b00000, 4'd2, 1'b0);
    send(128'hD801, 2);
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", 72'(in_ready), 72'd0);
      check("hold_out_valid", 72'(out_valid), 72'd1);
      check("hold_window", unescaped_instr, 72'hD801);
      check("hold_body_len", 72'(body_len), 72'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 72'(out_valid), 72'd0);
    check("release_in_ready", 72'(in_ready), 72'd1);
    drain();
    // Reset mid-instruction after 0x66,0x0F; the byte shown during reset must not be taken
    in_valid = 1'b1;
    in_byte = 8'h66;
    @(posedge clk); #1;
    in_byte = 8'h0F;
    @(posedge clk); #1;
    rst = 1'b1;
    in_byte = 8'h90;
    in_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    check_idle("midreset");
    @(posedge clk); #1;
    check_idle("midreset_next");
    push(72'h90, 5'b00000, 4'd1, 1'b0);
    send(128'h90, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
